// File: rtl/inst_adr_table.sv
// Run-time programmable key-to-routine-address table with valid bits, a one-cycle
// registered lookup path with valid/ready handshakes, and a saturating miss counter.
module inst_adr_table #(
   parameter int               IN_W     = 9,
   parameter int               OUT_W    = 7,
   parameter logic [OUT_W-1:0] MISS_VAL = '1,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IN_W-1:0]  cfg_addr,
   input  logic [OUT_W-1:0] cfg_data,
   input  logic             cfg_clear,
   output logic             busy,
   input  logic             lk_valid,
   output logic             lk_ready,
   input  logic [IN_W-1:0]  lk_key,
   output logic             rs_valid,
   input  logic             rs_ready,
   output logic [OUT_W-1:0] rs_addr,
   output logic             rs_hit,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int               DEPTH   = 1 << IN_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           state, state_nxt;
   logic [IN_W-1:0]  sweep_cnt, sweep_cnt_nxt;

   logic [OUT_W-1:0] data_mem  [DEPTH];
   logic             valid_mem [DEPTH];

   logic             run;
   logic             wr_en;
   logic             accept;
   logic             fwd;
   logic             rd_valid;
   logic [OUT_W-1:0] rd_data;
   logic             lk_hit;
   logic [OUT_W-1:0] lk_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         sweep_cnt <= '0;
      end else begin
         state     <= state_nxt;
         sweep_cnt <= sweep_cnt_nxt;
      end
   end

   // A clear request always restarts the sweep from entry 0, whichever state we are in.
   always_comb begin
      state_nxt     = state;
      sweep_cnt_nxt = sweep_cnt;
      if (cfg_clear) begin
         state_nxt     = CLEAR;
         sweep_cnt_nxt = '0;
      end else if (state == CLEAR) begin
         sweep_cnt_nxt = sweep_cnt + IN_W'(1);
         if (&sweep_cnt) begin
            state_nxt = RUN;
         end
      end
   end

   assign run      = (state == RUN);
   assign busy     = (state == CLEAR);
   assign wr_en    = run && cfg_we && !cfg_clear;
   assign lk_ready = run && (!rs_valid || rs_ready);
   assign accept   = lk_valid && lk_ready;
   assign fwd      = wr_en && (cfg_addr == lk_key);

   assign rd_valid = valid_mem[lk_key];
   assign rd_data  = data_mem[lk_key];

   // A write landing on the looked-up key in the same cycle wins over the stored entry.
   always_comb begin
      lk_hit  = fwd || rd_valid;
      lk_addr = MISS_VAL;
      if (fwd) begin
         lk_addr = cfg_data;
      end else if (rd_valid) begin
         lk_addr = rd_data;
      end
   end

   // Storage has no reset; the sweep is what makes the valid bits trustworthy.
   always_ff @(posedge clk) begin
      if (!run) begin
         valid_mem[sweep_cnt] <= 1'b0;
      end else if (wr_en) begin
         valid_mem[cfg_addr] <= 1'b1;
         data_mem[cfg_addr]  <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_valid <= 1'b0;
         rs_hit   <= 1'b0;
         rs_addr  <= '0;
      end else if (accept) begin
         rs_valid <= 1'b1;
         rs_hit   <= lk_hit;
         rs_addr  <= lk_addr;
      end else if (rs_ready) begin
         rs_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_cnt <= '0;
      end else if (cfg_clear) begin
         miss_cnt <= '0;
      end else if (rs_valid && rs_ready && !rs_hit && (miss_cnt != CNT_MAX)) begin
         miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/inst_adr_table.md
# inst_adr_table

Programmable, registered successor to the fixed opcode-to-microcode-address ROM in the JIT front end. It maps an `IN_W`-bit key (prefix bit plus bytecode opcode) to an `OUT_W`-bit translation-routine start address. Entries are loaded at run time through a configuration port, and every entry carries a valid bit. Lookups use a valid/ready handshake with one-cycle latency and report hit or miss explicitly, so the result needs no in-band sentinel.

## Interface
- `IN_W`, 9, key width; table depth is 2**`IN_W`
- `OUT_W`, 7, routine-address width
- `MISS_VAL`, all ones, value driven on `rs_addr` for a miss
- `CNT_W`, 16, miss-counter width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_we`  in  1  write entry: set valid, store data
- `cfg_addr`  in  `IN_W`  entry index
- `cfg_data`  in  `OUT_W`  routine address to store
- `cfg_clear`  in  1  one-cycle pulse: invalidate all entries, zero `miss_cnt`
- `busy`  out  1  clear sweep in progress
- `lk_valid`  in  1  lookup request
- `lk_ready`  out  1  lookup accepted this cycle when high together with `lk_valid`
- `lk_key`  in  `IN_W`  lookup key
- `rs_valid`  out  1  result available
- `rs_ready`  in  1  result consumed
- `rs_addr`  out  `OUT_W`  looked-up address, or `MISS_VAL`
- `rs_hit`  out  1  entry was valid
- `miss_cnt`  out  `CNT_W`  saturating count of delivered misses

## Operation
- **Storage.** The array has 2**`IN_W` entries. Each entry holds {valid, `OUT_W` data}. Reset does not initialise the data field; only the sweep clears the valid bits.
- **State machine.** Two states, CLEAR and RUN.
  - Async reset forces CLEAR with sweep counter = 0.
  - CLEAR writes valid=0 to entry [counter] each cycle and increments the counter.
  - After the cycle that clears entry 2**`IN_W`-1, the block moves to RUN.
  - `cfg_clear` in RUN moves to CLEAR with counter = 0.
  - `cfg_clear` during CLEAR restarts the counter at 0.
- **`busy`.** High exactly while in CLEAR.
- **Configuration writes.** Honoured only in RUN with `cfg_clear` low. Writes in CLEAR, or in the same cycle as `cfg_clear`, are silently dropped (clear wins).
- **Lookup accept.** `lk_ready` = RUN && (!`rs_valid` || `rs_ready`). Accept = `lk_valid` && `lk_ready`.
- **Result on accept.** The output register loads:
  - `rs_addr` = data if the entry is valid, otherwise `MISS_VAL`
  - `rs_hit` = entry valid
  - `rs_valid` = 1
- **No accept.** If `rs_ready` is high and there is no accept, `rs_valid` drops to 0.
- **Write-first forwarding.** If an accepted lookup key equals `cfg_addr` of an honoured write in the same cycle, the result is a hit returning `cfg_data`.
- **Backpressure.** While `rs_valid` && !`rs_ready`, `rs_addr` and `rs_hit` hold stable.
- **Clear with a pending result.** A result already registered when a clear starts stays held until it is consumed, and keeps its pre-clear value.
- **Miss counter.** `miss_cnt` increments by 1 on each handshake (`rs_valid` && `rs_ready`) with `rs_hit`=0, and saturates at 2**`CNT_W`-1. `cfg_clear` zeroes it in the same cycle; clear takes priority over increment.

## Timing
- **Reset values:**
  - `busy`=1, `lk_ready`=0
  - `rs_valid`=0, `rs_hit`=0, `rs_addr`=0
  - `miss_cnt`=0
- **Clear duration.** The sweep lasts 2**`IN_W` cycles (512 at default). `busy` falls on the edge after the last entry is cleared, and `lk_ready` may rise in that same cycle.
- **Lookup latency.** A lookup accepted at edge N presents its result (`rs_valid`=1) from edge N onward, i.e. one cycle after request.
- **Throughput.** One lookup per cycle with `rs_ready` held high.
- **Write visibility.** A write honoured at edge N is visible to lookups accepted at edge N (forwarded) and later.
- **Reset mid-transaction.** Async reset aborts it: the pending result is lost (`rs_valid`=0 immediately) and the full sweep reruns.

## Test plan
- **Reset and sweep.** Release `rst`, hold `lk_valid`=1 → `busy` high for exactly 512 cycles, and no accept until it falls. The first lookup, key 0x00B, returns `rs_hit`=0, `rs_addr`=0x7F, and `miss_cnt`=1 after the handshake.
- **Program and stream.** Write 0x00B→11, 0x100→2, 0x140→66, then stream those three keys with `rs_ready`=1 → three consecutive hits with addresses 11, 2, 66, one per cycle.
- **Forwarding.** Write 0x022→26 in the same cycle a lookup of 0x022 is accepted → `rs_hit`=1, `rs_addr`=26.
- **Backpressure.** Deassert `rs_ready` for 5 cycles with a result pending → `lk_ready`=0, and `rs_addr`/`rs_hit` stay unchanged. The next result appears one cycle after `rs_ready` returns.
- **Clear behaviour.** Pulse `cfg_clear` together with `cfg_we` (0x051→47) while a hit result is pending:
  - the pending result still delivers its old value;
  - after 512 cycles, a lookup of 0x051 misses;
  - `miss_cnt` restarts from 0.
- **Saturation.** With `CNT_W`=4, perform 20 miss handshakes → `miss_cnt`=15.
